data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
//
// Data-side memory responder for a small single-cycle core. It serves loads
// and stores from the core's memory stage with no stalls. It contains:
//   - a word-addressed RAM of MEM_WORDS 32-bit words
//   - a 16-bit LED register
//   - a free-running 32-bit cycle counter
//   - a byte FIFO that drains to an external consumer via a valid/ready pair
//   - a status register with a sticky overflow flag
//
// Address map (word granularity, ALUResult[1:0] ignored):
//   0x000 .. 4*MEM_WORDS-4 : RAM
//   0x800                  : LED       (read {16'b0, LED}; write WriteData[15:0])
//   0x804                  : CYCLE     (read only; writes ignored)
//   0x808                  : FIFO_DATA (write pushes WriteData[7:0]; read peeks head)
//   0x80C                  : STATUS    (read {count, OVF, EMPTY, FULL}; any write clears OVF)
//   Anything else reads as zero and ignores writes.
//
// Ports:
//   CLK        in   1  single clock, rising edge
//   Reset      in   1  synchronous active-high reset
//   MemWrite   in   1  store strobe
//   ALUResult  in  32  byte address
//   WriteData  in  32  store data
//   ReadData   out 32  load data, combinational from ALUResult
//   LED        out 16  LED register
//   OutData    out  8  FIFO head byte (0 when empty)
//   OutValid   out  1  FIFO non-empty
//   OutReady   in   1  consumer accepts the head on an edge where OutValid=1
// ============================================================================
module data_mem_responder #(
    parameter int MEM_WORDS  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] LED,
    output logic [7:0]  OutData,
    output logic        OutValid,
    input  logic        OutReady
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0] LED_WORD    = 30'h200;
    localparam logic [29:0] CYCLE_WORD  = 30'h201;
    localparam logic [29:0] FIFO_WORD   = 30'h202;
    localparam logic [29:0] STATUS_WORD = 30'h203;

    // ------------------------------------------------------------------------
    // Address decode. The byte offset within a word never affects decoding,
    // so the whole map is matched on the 30-bit word address. With the
    // largest RAM size the RAM range would cover 0x800..0x80C, so the
    // peripheral registers take priority there and shadow those RAM words.
    // ------------------------------------------------------------------------
    logic [29:0]   word_addr;
    logic          unused_byte_offset;
    logic          led_hit;
    logic          cycle_hit;
    logic          fifo_hit;
    logic          status_hit;
    logic          periph_hit;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;

    assign word_addr          = ALUResult[31:2];
    assign unused_byte_offset = ^ALUResult[1:0];
    assign led_hit            = (word_addr == LED_WORD);
    assign cycle_hit          = (word_addr == CYCLE_WORD);
    assign fifo_hit           = (word_addr == FIFO_WORD);
    assign status_hit         = (word_addr == STATUS_WORD);
    assign periph_hit         = led_hit | cycle_hit | fifo_hit | status_hit;
    assign ram_hit            = !periph_hit && (word_addr < 30'(MEM_WORDS));
    assign ram_idx            = ALUResult[AW+1:2];

    // ------------------------------------------------------------------------
    // Storage arrays and register state.
    // ------------------------------------------------------------------------
    logic [31:0]   ram_mem  [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [15:0]   led_q,    led_d;
    logic [31:0]   cycle_q,  cycle_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    // ------------------------------------------------------------------------
    // FIFO handshake terms. A push into a full FIFO is still accepted when
    // the head leaves on the same edge, because the slot being written is
    // exactly the one being vacated.
    // ------------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && OutReady;
    assign push_req   = MemWrite && fifo_hit;
    assign push_ok    = push_req && (!fifo_full || pop);

    // ------------------------------------------------------------------------
    // RAM write port. RAM is deliberately not cleared by reset so that its
    // contents survive a core restart, but a store issued in a reset cycle is
    // still discarded. Because the read path is combinational off the array,
    // a load of the word being written sees the old contents this cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!Reset && MemWrite && ram_hit) begin
            ram_mem[ram_idx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage write. The slots themselves need no reset: the head is
    // only exposed while the count says it is valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!Reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic for the registers. Pointers are PW bits wide so they
    // wrap modulo FIFO_DEPTH on their own; the count needs one extra bit so
    // that a completely full FIFO is distinguishable from an empty one.
    // Overflow is sticky until software writes STATUS; the two cannot
    // collide since only one address is written per cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        led_d    = led_q;
        cycle_d  = cycle_q + 32'd1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (MemWrite && led_hit) begin
            led_d = WriteData[15:0];
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (MemWrite && status_hit) begin
            ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register update. Reset wins over any store or pop in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            led_q    <= '0;
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Consumer-side outputs. OutData is forced to zero while empty so stale
    // slot contents never leak out, and a freshly pushed byte only appears
    // after the edge that stores it.
    // ------------------------------------------------------------------------
    logic [31:0] status_word;

    assign OutValid    = !fifo_empty;
    assign OutData     = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];
    assign LED         = led_q;
    assign status_word = {24'b0, 5'(count_q), ovf_q, fifo_empty, fifo_full};

    // ------------------------------------------------------------------------
    // Load data mux, purely combinational from the address so loads finish
    // in the same cycle. Unmapped addresses fall through to zero.
    // ------------------------------------------------------------------------
    always_comb begin
        ReadData = 32'h0000_0000;
        if (ram_hit) begin
            ReadData = ram_mem[ram_idx];
        end else if (led_hit) begin
            ReadData = {16'b0, led_q};
        end else if (cycle_hit) begin
            ReadData = cycle_q;
        end else if (fifo_hit) begin
            ReadData = {24'b0, OutData};
        end else if (status_hit) begin
            ReadData = status_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A behavioural model holds the
// RAM as an array, the FIFO as a byte queue and the counters as plain
// integers. Every cycle the DUT outputs are compared against it. Directed
// scenarios cover the documented corner cases, followed by a random phase.
// ============================================================================
module tb_data_mem_responder;

    localparam int MEM_WORDS  = 128;
    localparam int FIFO_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] LED;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] refRam   [MEM_WORDS];
    bit          refKnown [MEM_WORDS];
    logic [15:0] refLed;
    logic [31:0] refCycle;
    logic [7:0]  refQ [$];
    bit          refOvf;

    logic [31:0] lastRead;
    logic [7:0]  lastOut;
    logic        lastValid;
    logic [15:0] lastLed;

    data_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .LED      (LED),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady)
    );

    // Free-running 100 MHz-style clock.
    always #5 CLK = ~CLK;

    // Hard stop in case something ever stops the stimulus from advancing.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Expected STATUS value computed arithmetically from the model queue.
    function automatic logic [31:0] expectedStatus();
        int n;
        n = refQ.size();
        return 32'(n * 8 + (refOvf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FIFO_DEPTH ? 1 : 0));
    endfunction

    // Expected load value; known=0 means the RAM word was never written.
    task automatic expectedRead(input logic [31:0] addr, output logic [31:0] value,
                                output bit known);
        logic [31:0] aligned;
        aligned = addr & 32'hFFFF_FFFC;
        known   = 1'b1;
        value   = 32'h0;
        if (aligned == 32'h800)      value = {16'h0, refLed};
        else if (aligned == 32'h804) value = refCycle;
        else if (aligned == 32'h808) value = (refQ.size() != 0) ? {24'h0, refQ[0]} : 32'h0;
        else if (aligned == 32'h80C) value = expectedStatus();
        else if (aligned < 32'(4 * MEM_WORDS)) begin
            known = refKnown[aligned / 4];
            value = refRam[aligned / 4];
        end
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic ready);
        logic [31:0] expRead;
        bit          known;
        logic [31:0] aligned;
        bit          popNow;

        Reset     = rst;
        MemWrite  = we;
        ALUResult = addr;
        WriteData = wdata;
        OutReady  = ready;

        @(negedge CLK);
        lastRead  = ReadData;
        lastOut   = OutData;
        lastValid = OutValid;
        lastLed   = LED;

        checkOutput("out_valid", {31'b0, OutValid}, {31'b0, refQ.size() != 0});
        checkOutput("out_data", {24'b0, OutData}, (refQ.size() != 0) ? {24'b0, refQ[0]} : 32'h0);
        checkOutput("led", {16'b0, LED}, {16'b0, refLed});
        expectedRead(addr, expRead, known);
        if (known) checkOutput("read_data", ReadData, expRead);

        @(posedge CLK);
        if (rst) begin
            refLed   = '0;
            refCycle = '0;
            refQ.delete();
            refOvf   = 1'b0;
        end else begin
            aligned = addr & 32'hFFFF_FFFC;
            popNow  = (refQ.size() != 0) && ready;
            if (we) begin
                if (aligned == 32'h800) refLed = wdata[15:0];
                else if (aligned == 32'h80C) refOvf = 1'b0;
                else if (aligned < 32'(4 * MEM_WORDS)) begin
                    refRam[aligned / 4]   = wdata;
                    refKnown[aligned / 4] = 1'b1;
                end
            end
            if (popNow) void'(refQ.pop_front());
            if (we && aligned == 32'h808) begin
                if (refQ.size() < FIFO_DEPTH) refQ.push_back(wdata[7:0]);
                else refOvf = 1'b1;
            end
            refCycle = refCycle + 32'd1;
        end
        #1;
    endtask

    // Stimulus sequence: directed corner cases, then a random phase.
    initial begin
        logic [31:0] c0;
        logic [7:0]  inBytes [$];
        logic [7:0]  outBytes [$];
        logic [31:0] addr;
        int          kind;

        for (int i = 0; i < MEM_WORDS; i++) refKnown[i] = 1'b0;
        Reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        OutReady  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        refLed   = '0;
        refCycle = '0;
        refQ.delete();
        refOvf   = 1'b0;

        // Reset state.
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("reset_status", lastRead, 32'h0000_0002);
        checkOutput("reset_valid", {31'b0, lastValid}, 32'h0);

        // RAM write/read, read-during-write and unmapped access.
        applyStimulus(0, 1, 32'h004, 32'h1111_1111, 0);
        applyStimulus(0, 1, 32'h004, 32'hDEAD_BEEF, 0);
        checkOutput("ram_old_on_write", lastRead, 32'h1111_1111);
        applyStimulus(0, 0, 32'h004, 0, 0);
        checkOutput("ram_read", lastRead, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 32'h1000, 32'hCAFE_F00D, 0);
        applyStimulus(0, 0, 32'h1000, 0, 0);
        checkOutput("unmapped_read", lastRead, 32'h0);
        applyStimulus(0, 0, 32'h007, 0, 0);
        checkOutput("ram_byte_offset", lastRead, 32'hDEAD_BEEF);

        // LED register.
        applyStimulus(0, 1, 32'h800, 32'h1234_ABCD, 0);
        applyStimulus(0, 0, 32'h800, 0, 0);
        checkOutput("led_port", {16'b0, lastLed}, 32'h0000_ABCD);
        checkOutput("led_read", lastRead, 32'h0000_ABCD);

        // Cycle counter: reads five cycles apart differ by five; writes ignored.
        applyStimulus(0, 0, 32'h804, 0, 0);
        c0 = lastRead;
        applyStimulus(0, 1, 32'h804, 32'hFFFF_0000, 0);
        repeat (3) applyStimulus(0, 0, 32'h1000, 0, 0);
        applyStimulus(0, 0, 32'h804, 0, 0);
        checkOutput("cycle_delta", lastRead - c0, 32'd5);

        // FIFO fill past full with the consumer stalled.
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'h808, 32'(8'h11 + i), 0);
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("fill_status", lastRead, 32'h0000_0025);
        checkOutput("fill_head", {24'b0, lastOut}, 32'h11);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 32'h1000, 0, 1);
            checkOutput("drain_order", {24'b0, lastOut}, 32'(8'h11 + i));
        end
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("drained_status", lastRead, 32'h0000_0006);

        // Clearing OVF through a STATUS write of zero.
        applyStimulus(0, 1, 32'h80C, 32'h0, 0);
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("ovf_clear", lastRead, 32'h0000_0002);

        // Push into a full FIFO while the head is popped.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'h808, 32'(8'hA1 + i), 0);
        applyStimulus(0, 1, 32'h808, 32'h0000_00AA, 1);
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("full_pushpop_status", lastRead, 32'h0000_0021);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h1000, 0, 1);
        checkOutput("full_pushpop_tail", {24'b0, lastOut}, 32'h0000_00AA);

        // Reset with entries queued, plus a store and pop in the reset cycle.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h808, 32'(8'h51 + i), 0);
        applyStimulus(1, 1, 32'h800, 32'h0000_FFFF, 1);
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("post_reset_status", lastRead, 32'h0000_0002);
        checkOutput("post_reset_valid", {31'b0, lastValid}, 32'h0);
        checkOutput("post_reset_led", {16'b0, lastLed}, 32'h0);
        applyStimulus(0, 0, 32'h804, 0, 0);
        checkOutput("post_reset_cycle", lastRead, 32'd1);
        applyStimulus(0, 0, 32'h004, 0, 0);
        checkOutput("ram_retained", lastRead, 32'hDEAD_BEEF);

        // Pointer wrap: ten push/pop pairs stream straight through.
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                inBytes.push_back(8'($urandom));
                applyStimulus(0, 1, 32'h808, {24'b0, inBytes[i]}, 1);
            end else begin
                applyStimulus(0, 0, 32'h1000, 0, 1);
            end
            if (lastValid) outBytes.push_back(lastOut);
        end
        checkOutput("wrap_count", 32'(outBytes.size()), 32'd10);
        for (int i = 0; i < 10 && i < outBytes.size(); i++)
            checkOutput("wrap_byte", {24'b0, outBytes[i]}, {24'b0, inBytes[i]});
        applyStimulus(0, 0, 32'h80C, 0, 0);
        checkOutput("wrap_status", lastRead, 32'h0000_0002);

        // Random traffic across the whole map.
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2: addr = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
                3:       addr = 32'h800;
                4:       addr = 32'h804;
                5, 6:    addr = 32'h808 | 32'($urandom_range(0, 3));
                7:       addr = 32'h80C;
                8:       addr = ($urandom_range(0, 1) == 0) ? 32'h200 : 32'h810;
                default: addr = $urandom | 32'h0000_1000;
            endcase
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), addr,
                          $urandom, $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
